// File: rtl/hbm_axi3_wr_gen_if.sv
// rtl/hbm_axi3_wr_gen_if.sv - AXI3 write-only (AW/W/B) channel bundle for one HBM pseudo-channel port
interface hbm_axi3_wr_gen_if #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/hbm_axi3_wr_gen.sv
// rtl/hbm_axi3_wr_gen.sv - AXI3 INCR write traffic generator with response counting and run timer
module hbm_axi3_wr_gen #(
    parameter int ID_WIDTH        = 6,
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [31:0]           num_bursts_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           cycle_count_o,
    hbm_axi3_wr_gen_if.master     axi_m
);
    localparam int                    STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int                    WORDS       = DATA_WIDTH / 32;
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * STRB_WIDTH);
    localparam logic [3:0]            AWLEN       = 4'(BURST_LEN - 1);
    localparam logic [2:0]            AWSIZE      = 3'($clog2(STRB_WIDTH));
    localparam logic [31:0]           MAX_OUT     = 32'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e                state_q, state_d;
    logic [31:0]           num_bursts_q, num_bursts_d;
    logic [31:0]           aw_cnt_q, aw_cnt_d;
    logic [31:0]           w_burst_cnt_q, w_burst_cnt_d;
    logic [31:0]           beat_idx_q, beat_idx_d;
    logic [31:0]           b_cnt_q, b_cnt_d;
    logic [31:0]           cycle_count_q, cycle_count_d;
    logic [3:0]            beat_in_burst_q, beat_in_burst_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  err_q, err_d;
    logic                  run, aw_hs, w_hs, b_hs;
    logic                  unused_bid;

    assign unused_bid    = ^axi_m.bid;

    assign axi_m.awid    = '0;
    assign axi_m.awaddr  = awaddr_q;
    assign axi_m.awlen   = AWLEN;
    assign axi_m.awsize  = AWSIZE;
    assign axi_m.awburst = 2'b01;
    assign axi_m.awlock  = 2'b00;
    assign axi_m.awcache = 4'b0011;
    assign axi_m.awprot  = 3'b000;
    assign axi_m.awqos   = 4'b0000;
    assign axi_m.wstrb   = '1;
    assign axi_m.wdata   = {WORDS{beat_idx_q}};

    assign busy_o        = (state_q == ST_RUN);
    assign done_o        = (state_q == ST_DONE);
    assign err_o         = err_q;
    assign cycle_count_o = cycle_count_q;

    always_comb begin
        state_d         = state_q;
        num_bursts_d    = num_bursts_q;
        aw_cnt_d        = aw_cnt_q;
        w_burst_cnt_d   = w_burst_cnt_q;
        beat_idx_d      = beat_idx_q;
        b_cnt_d         = b_cnt_q;
        cycle_count_d   = cycle_count_q;
        beat_in_burst_d = beat_in_burst_q;
        awaddr_d        = awaddr_q;
        err_d           = err_q;

        run = (state_q == ST_RUN);
        // Outstanding window counts accepted AWs not yet answered; a B in the same cycle frees a slot next cycle.
        axi_m.awvalid = run && (aw_cnt_q < num_bursts_q) && ((aw_cnt_q - b_cnt_q) < MAX_OUT);
        axi_m.wvalid  = run && (w_burst_cnt_q < aw_cnt_q);
        axi_m.wlast   = axi_m.wvalid && (beat_in_burst_q == AWLEN);
        axi_m.bready  = run;

        aw_hs = axi_m.awvalid && axi_m.awready;
        w_hs  = axi_m.wvalid && axi_m.wready;
        b_hs  = axi_m.bvalid && axi_m.bready;

        if (run) begin
            if (cycle_count_q != 32'hFFFF_FFFF) begin
                cycle_count_d = cycle_count_q + 32'd1;
            end
            if (aw_hs) begin
                aw_cnt_d = aw_cnt_q + 32'd1;
                awaddr_d = awaddr_q + BURST_BYTES;
            end
            if (w_hs) begin
                beat_idx_d = beat_idx_q + 32'd1;
                if (axi_m.wlast) begin
                    beat_in_burst_d = 4'd0;
                    w_burst_cnt_d   = w_burst_cnt_q + 32'd1;
                end else begin
                    beat_in_burst_d = beat_in_burst_q + 4'd1;
                end
            end
            if (b_hs) begin
                b_cnt_d = b_cnt_q + 32'd1;
                if (axi_m.bresp != 2'b00) begin
                    err_d = 1'b1;
                end
                if (b_cnt_q + 32'd1 == num_bursts_q) begin
                    state_d = ST_DONE;
                end
            end
        end else if (start_i) begin
            num_bursts_d    = num_bursts_i;
            awaddr_d        = base_addr_i;
            aw_cnt_d        = 32'd0;
            w_burst_cnt_d   = 32'd0;
            beat_idx_d      = 32'd0;
            b_cnt_d         = 32'd0;
            cycle_count_d   = 32'd0;
            beat_in_burst_d = 4'd0;
            err_d           = 1'b0;
            state_d         = (num_bursts_i != 32'd0) ? ST_RUN : ST_DONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            num_bursts_q    <= 32'd0;
            aw_cnt_q        <= 32'd0;
            w_burst_cnt_q   <= 32'd0;
            beat_idx_q      <= 32'd0;
            b_cnt_q         <= 32'd0;
            cycle_count_q   <= 32'd0;
            beat_in_burst_q <= 4'd0;
            awaddr_q        <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            num_bursts_q    <= num_bursts_d;
            aw_cnt_q        <= aw_cnt_d;
            w_burst_cnt_q   <= w_burst_cnt_d;
            beat_idx_q      <= beat_idx_d;
            b_cnt_q         <= b_cnt_d;
            cycle_count_q   <= cycle_count_d;
            beat_in_burst_q <= beat_in_burst_d;
            awaddr_q        <= awaddr_d;
            err_q           <= err_d;
        end
    end
endmodule
